radix4_seq_divider: RTL and testbench

//  Sequential signed 32/32 integer divider. It is the inverse-operation partner of the

---
 rtl/radix4_seq_divider_pkg.sv | 17 +
 rtl/radix4_seq_divider_if.sv | 24 ++
 rtl/radix4_div_step.sv | 34 +++
 rtl/radix4_seq_divider.sv | 128 ++++++++++++
 tb/tb_radix4_seq_divider.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/radix4_seq_divider_pkg.sv
// Shared definitions for the radix-4 sequential divider: FSM encoding and sizing helpers.
package radix4_seq_divider_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Two quotient bits per iteration.
  function automatic int unsigned iter_count(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/radix4_seq_divider_if.sv
// Request/result bundle between the arithmetic unit and the radix-4 divider.
interface radix4_seq_divider_if #(
  parameter int unsigned WIDTH = radix4_seq_divider_pkg::DEF_WIDTH
);
  logic             en;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output en, start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  en, start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/radix4_div_step.sv
// One radix-4 restoring step: picks the largest digit in 0..3 with digit*D <= R'.
module radix4_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH+1:0] rp,
  input  logic [WIDTH+1:0] d,
  input  logic [WIDTH+1:0] d3,
  output logic [1:0]       digit,
  output logic [WIDTH+1:0] rnext
);
  localparam int unsigned RW = WIDTH + 2;

  // One extra bit on each difference acts as the borrow flag.
  logic [RW:0] s1, s2, s3;

  assign s1 = {1'b0, rp} - {1'b0, d};
  assign s2 = {1'b0, rp} - {d, 1'b0};
  assign s3 = {1'b0, rp} - {1'b0, d3};

  always_comb begin
    digit = 2'd0;
    rnext = rp;
    if (!s3[RW]) begin
      digit = 2'd3;
      rnext = s3[RW-1:0];
    end else if (!s2[RW]) begin
      digit = 2'd2;
      rnext = s2[RW-1:0];
    end else if (!s1[RW]) begin
      digit = 2'd1;
      rnext = s1[RW-1:0];
    end
  end
endmodule

// File: rtl/radix4_seq_divider.sv
// Signed WIDTH/WIDTH sequential divider, two quotient bits per enabled cycle, C semantics.
module radix4_seq_divider
  import radix4_seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  radix4_seq_divider_if.slave   bus
);
  localparam int unsigned ITER = iter_count(WIDTH);
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned RW   = WIDTH + 2;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, q_q, q_d, quo_q, quo_d, rem_q, rem_d;
  logic [RW-1:0]    d_q, d_d, d3_q, d3_d, r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d, sb_q, sb_d, done_q, done_d, dbz_q, dbz_d;

  logic [RW-1:0]    r_shift, r_next;
  logic [1:0]       digit;
  logic [WIDTH-1:0] abs_a, abs_b;

  // Magnitudes are unsigned, so the most negative operand is represented exactly.
  assign abs_a   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign abs_b   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign r_shift = {r_q[RW-3:0], n_q[WIDTH-1 -: 2]};

  radix4_div_step #(.WIDTH(WIDTH)) u_step (
    .rp    (r_shift),
    .d     (d_q),
    .d3    (d3_q),
    .digit (digit),
    .rnext (r_next)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    q_d     = q_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    d_d     = d_q;
    d3_d    = d3_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d  = bus.dividend[WIDTH-1];
          sb_d  = bus.divisor[WIDTH-1];
          dbz_d = 1'b0;
          if (bus.divisor == '0) begin
            quo_d  = '1;
            rem_d  = bus.dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            n_d     = abs_a;
            d_d     = {2'b00, abs_b};
            d3_d    = {2'b00, abs_b} + {1'b0, abs_b, 1'b0};
            r_d     = '0;
            q_d     = '0;
            cnt_d   = '0;
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        n_d   = {n_q[WIDTH-3:0], 2'b00};
        r_d   = r_next;
        q_d   = {q_q[WIDTH-3:0], digit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        quo_d   = (sa_q ^ sb_q) ? -q_q : q_q;
        rem_d   = sa_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      q_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      d_q     <= '0;
      d3_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (bus.en) begin
      state_q <= state_d;
      n_q     <= n_d;
      q_q     <= q_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      d_q     <= d_d;
      d3_q    <= d3_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_radix4_seq_divider.sv
// Self-checking bench: directed corner cases plus random operands against a 64-bit C-style model.
module tb_radix4_seq_divider;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  radix4_seq_divider_if #(.WIDTH(32)) bus ();

  radix4_seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // C semantics via wide signed arithmetic; low 32 bits give the wrapped overflow case.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output bit dz);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      dz = 1'b0;
    end
  endfunction

  // Called away from the clock edge; returns #1 after an edge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int stall_at,
                        input int stall_len, input bit poke, input bit chain);
    logic [31:0] eq, er;
    bit          edz;
    int          k, busy_cnt, exp_lat, exp_busy;
    string       id;
    model(a, b, eq, er, edz);
    id           = $sformatf("%0d/%0d", $signed(a), $signed(b));
    exp_lat      = (b == 32'd0) ? 1 : 18 + stall_len;
    exp_busy     = (b == 32'd0) ? 0 : 17 + stall_len;
    bus.en       = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k         = 1;
    busy_cnt  = 0;
    while (!bus.done && k < 60) begin
      if (bus.busy) busy_cnt++;
      bus.en = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
      if (poke && k == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd55;
        bus.divisor  = 32'd5;
      end
      if (poke && k == 6) bus.start = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;
    check({"latency ", id}, 64'(k), 64'(exp_lat));
    check({"busy cycles ", id}, 64'(busy_cnt), 64'(exp_busy));
    check({"quotient ", id}, 64'(bus.quotient), 64'(eq));
    check({"remainder ", id}, 64'(bus.remainder), 64'(er));
    check({"div_by_zero ", id}, 64'(bus.div_by_zero), 64'(edz));
    if (!chain) begin
      @(posedge clk);
      #1;
      check({"done pulse ", id}, 64'(bus.done), 64'd0);
      check({"idle ", id}, 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          st_at, st_len;
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset quotient", 64'(bus.quotient), 64'd0);
    check("reset remainder", 64'(bus.remainder), 64'd0);
    check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_div(32'd1348760118, 32'd840, 0, 0, 1'b0, 1'b0);
    do_div(-32'sd553524, 32'd259, 0, 0, 1'b0, 1'b0);
    do_div(32'd7, -32'sd2, 0, 0, 1'b0, 1'b0);
    do_div(-32'sd7, -32'sd2, 0, 0, 1'b0, 1'b0);
    do_div(32'd12345, 32'd0, 0, 0, 1'b0, 1'b0);
    do_div(32'd10, 32'd3, 0, 0, 1'b0, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    do_div(32'h8000_0000, 32'd1, 0, 0, 1'b0, 1'b0);
    do_div(32'd0, -32'sd5, 0, 0, 1'b0, 1'b0);
    do_div(32'd100, 32'd7, 5, 5, 1'b0, 1'b0);
    do_div(32'd100, 32'd7, 0, 0, 1'b1, 1'b0);

    // A done pulse must survive a stall and clear on the first enabled edge.
    do_div(32'd20, 32'd6, 0, 0, 1'b0, 1'b1);
    bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done held in stall", 64'(bus.done), 64'd1);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    check("done cleared after stall", 64'(bus.done), 64'd0);

    // Abort mid-operation with an asynchronous reset.
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort quotient", 64'(bus.quotient), 64'd0);
    check("abort remainder", 64'(bus.remainder), 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("abort no done", 64'(bus.done), 64'd0);
      if (i == 2) begin
        @(negedge clk);
        reset = 1'b0;
      end
    end
    do_div(32'd1000, 32'd3, 0, 0, 1'b0, 1'b0);

    // Back-to-back: each new start lands in the previous done cycle.
    do_div(32'd1000, 32'd3, 0, 0, 1'b0, 1'b1);
    do_div(-32'sd99, 32'd4, 0, 0, 1'b0, 1'b1);
    do_div(32'd77, 32'd0, 0, 0, 1'b0, 1'b1);
    do_div(32'd5, 32'd9, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra = ra >> $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(0, 40)) - 32'd20;
        2:       rb = $urandom >> $urandom_range(8, 31);
        default: rb = -($urandom >> $urandom_range(4, 31));
      endcase
      st_at  = 0;
      st_len = 0;
      if ($urandom_range(0, 3) == 0) begin
        st_at  = $urandom_range(1, 15);
        st_len = $urandom_range(1, 4);
      end
      if (rb == 32'd0) st_len = 0;
      do_div(ra, rb, st_at, st_len, 1'b0, ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
